multicycle_ctrl: RTL and testbench

//  Main FSM of the multi-cycle RV32I core: sequences one shared ALU, one memory port and the register file.

---
 rtl/multicycle_ctrl_pkg.sv | 98 +++++++++
 rtl/multicycle_ctrl_alu_op_decode.sv | 53 +++++
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control FSM: state codes, opcodes,
// datapath select codes, ALU operation codes and the per-cycle control bundle.
package multicycle_ctrl_pkg;

  // FSM state codes
  localparam logic [2:0] StIf   = 3'd0;
  localparam logic [2:0] StId   = 3'd1;
  localparam logic [2:0] StEx   = 3'd2;
  localparam logic [2:0] StMem  = 3'd3;
  localparam logic [2:0] StWb   = 3'd4;
  localparam logic [2:0] StHalt = 3'd5;

  // RV32I major opcodes handled by this core
  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcI      = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcSystem = 7'b1110011;

  // ALU operand A select
  localparam logic [1:0] SrcAPc    = 2'd0;
  localparam logic [1:0] SrcAOldPc = 2'd1;
  localparam logic [1:0] SrcARegA  = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SrcBRegB  = 2'd0;
  localparam logic [1:0] SrcBFour  = 2'd1;
  localparam logic [1:0] SrcBImm   = 2'd2;
  localparam logic [1:0] SrcBZero  = 2'd3;

  // Register file write data select
  localparam logic [1:0] RdAluOut  = 2'd0;
  localparam logic [1:0] RdMdr     = 2'd1;
  localparam logic [1:0] RdPc      = 2'd2;

  // ALU operation codes shared with the ALU
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluOr   = 4'd7;
  localparam logic [3:0] AluAnd  = 4'd8;
  localparam logic [3:0] AluBeq  = 4'd9;
  localparam logic [3:0] AluBne  = 4'd10;
  localparam logic [3:0] AluBlt  = 4'd11;
  localparam logic [3:0] AluBge  = 4'd12;
  localparam logic [3:0] AluBltu = 4'd13;
  localparam logic [3:0] AluBgeu = 4'd14;
  localparam logic [3:0] AluEca  = 4'd15;

  typedef enum logic [2:0] {
    ClsNone,
    ClsAlu,
    ClsMem,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsEcall
  } insn_class_e;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       old_pc_write;
    logic       pc_write;
    logic       pc_source;
    logic       aluout_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] rd_src;
    logic       is_ecall;
  } ctrl_t;

  function automatic insn_class_e decode_class(input logic [6:0] opcode);
    insn_class_e cls;
    unique case (opcode)
      OpcR, OpcI:         cls = ClsAlu;
      OpcLoad, OpcStore:  cls = ClsMem;
      OpcBranch:          cls = ClsBranch;
      OpcJal:             cls = ClsJal;
      OpcJalr:            cls = ClsJalr;
      OpcSystem:          cls = ClsEcall;
      default:            cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational ALU operation decode from FSM state and IR fields. Outside EX the
// ALU is only used for address/PC arithmetic, so it defaults to ADD.
module multicycle_ctrl_alu_op_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned AluOpW = 4
) (
  input  logic [2:0]        state_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7_5_i,
  output logic [AluOpW-1:0] alu_op_o
);

  logic [3:0] op;

  always_comb begin
    op = AluAdd;
    if (state_i == StEx) begin
      case (decode_class(opcode_i))
        ClsAlu: begin
          unique case (funct3_i)
            // funct7_5 selects SUB only for register-register ops; ADDI ignores it
            3'b000:  op = (opcode_i == OpcR && funct7_5_i) ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = AluSrl;   // no arithmetic shift in this core
            3'b110:  op = AluOr;
            3'b111:  op = AluAnd;
            default: op = AluAdd;
          endcase
        end
        ClsBranch: begin
          case (funct3_i)
            3'b001:  op = AluBne;
            3'b100:  op = AluBlt;
            3'b101:  op = AluBge;
            3'b110:  op = AluBltu;
            3'b111:  op = AluBgeu;
            default: op = AluBeq;
          endcase
        end
        ClsEcall: op = AluEca;
        default:  op = AluAdd;
      endcase
    end
  end

  assign alu_op_o = AluOpW'(op);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32I core. Drives the shared ALU, the
// single memory port and the register file write controls cycle by cycle.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned AluOpW    = 4,
  parameter bit          EcallHalt = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic              funct7_5_i,
  input  logic              alu_bcond_i,
  input  logic              mem_ready_i,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              iord_o,
  output logic              ir_write_o,
  output logic              mdr_write_o,
  output logic              old_pc_write_o,
  output logic              pc_write_o,
  output logic              pc_source_o,
  output logic              aluout_write_o,
  output logic [1:0]        alu_src_a_o,
  output logic [1:0]        alu_src_b_o,
  output logic [AluOpW-1:0] alu_op_o,
  output logic              reg_write_o,
  output logic [1:0]        rd_src_o,
  output logic              is_ecall_o,
  output logic              halt_o
);

  logic [2:0]        state_q, state_d;
  insn_class_e       cls;
  logic              is_load;
  ctrl_t             ctrl;
  logic [AluOpW-1:0] alu_op;

  assign cls     = decode_class(opcode_i);
  assign is_load = (opcode_i == OpcLoad);

  multicycle_ctrl_alu_op_decode #(
    .AluOpW(AluOpW)
  ) u_alu_op_decode (
    .state_i   (state_q),
    .opcode_i  (opcode_i),
    .funct3_i  (funct3_i),
    .funct7_5_i(funct7_5_i),
    .alu_op_o  (alu_op)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      StIf: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SrcAPc;
        ctrl.alu_src_b = SrcBFour;
        if (mem_ready_i) begin
          ctrl.ir_write     = 1'b1;
          ctrl.old_pc_write = 1'b1;
          ctrl.pc_write     = 1'b1;
          state_d           = StId;
        end
      end
      StId: begin
        // Precompute old_pc + imm so branches and JAL find their target in ALUOut
        ctrl.alu_src_a    = SrcAOldPc;
        ctrl.alu_src_b    = SrcBImm;
        ctrl.aluout_write = 1'b1;
        ctrl.is_ecall     = (cls == ClsEcall);
        state_d           = (cls == ClsNone) ? StIf : StEx;
      end
      StEx: begin
        state_d = StIf;
        case (cls)
          ClsAlu: begin
            ctrl.alu_src_a    = SrcARegA;
            ctrl.alu_src_b    = (opcode_i == OpcR) ? SrcBRegB : SrcBImm;
            ctrl.aluout_write = 1'b1;
            state_d           = StWb;
          end
          ClsMem: begin
            ctrl.alu_src_a    = SrcARegA;
            ctrl.alu_src_b    = SrcBImm;
            ctrl.aluout_write = 1'b1;
            state_d           = StMem;
          end
          ClsBranch: begin
            ctrl.alu_src_a = SrcARegA;
            ctrl.alu_src_b = SrcBRegB;
            if (alu_bcond_i) begin
              ctrl.pc_write  = 1'b1;
              ctrl.pc_source = 1'b1;
            end
          end
          ClsJal: begin
            ctrl.reg_write = 1'b1;
            ctrl.rd_src    = RdPc;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b1;
          end
          ClsJalr: begin
            ctrl.alu_src_a = SrcARegA;
            ctrl.alu_src_b = SrcBImm;
            ctrl.reg_write = 1'b1;
            ctrl.rd_src    = RdPc;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 1'b0;
          end
          ClsEcall: begin
            ctrl.is_ecall  = 1'b1;
            ctrl.alu_src_a = SrcARegA;
            if (alu_bcond_i && EcallHalt) begin
              state_d = StHalt;
            end
          end
          default: state_d = StIf;
        endcase
      end
      StMem: begin
        ctrl.iord = 1'b1;
        if (is_load) begin
          ctrl.mem_read = 1'b1;
          if (mem_ready_i) begin
            ctrl.mdr_write = 1'b1;
            state_d        = StWb;
          end
        end else begin
          ctrl.mem_write = 1'b1;
          if (mem_ready_i) begin
            state_d = StIf;
          end
        end
      end
      StWb: begin
        ctrl.reg_write = 1'b1;
        ctrl.rd_src    = is_load ? RdMdr : RdAluOut;
        state_d        = StIf;
      end
      StHalt: state_d = StHalt;
      default: state_d = StIf;
    endcase
  end

  // Reset forces every output low combinationally so an in-flight request drops at once
  assign mem_read_o     = rst_ni & ctrl.mem_read;
  assign mem_write_o    = rst_ni & ctrl.mem_write;
  assign iord_o         = rst_ni & ctrl.iord;
  assign ir_write_o     = rst_ni & ctrl.ir_write;
  assign mdr_write_o    = rst_ni & ctrl.mdr_write;
  assign old_pc_write_o = rst_ni & ctrl.old_pc_write;
  assign pc_write_o     = rst_ni & ctrl.pc_write;
  assign pc_source_o    = rst_ni & ctrl.pc_source;
  assign aluout_write_o = rst_ni & ctrl.aluout_write;
  assign alu_src_a_o    = rst_ni ? ctrl.alu_src_a : 2'd0;
  assign alu_src_b_o    = rst_ni ? ctrl.alu_src_b : 2'd0;
  assign alu_op_o       = rst_ni ? alu_op : '0;
  assign reg_write_o    = rst_ni & ctrl.reg_write;
  assign rd_src_o       = rst_ni ? ctrl.rd_src : 2'd0;
  assign is_ecall_o     = rst_ni & ctrl.is_ecall;
  assign halt_o         = rst_ni & (state_q == StHalt);

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(mem_read_o && mem_write_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   reg_write_o |-> (state_q == StEx || state_q == StWb));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for the multi-cycle control FSM: walks instruction classes
// through their state sequences and checks the per-cycle control outputs.
module tb_multicycle_ctrl;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpSlt = 4'd3;
  localparam logic [3:0] OpSrl = 4'd6;
  localparam logic [3:0] OpAnd = 4'd8;
  localparam logic [3:0] OpBeq = 4'd9;
  localparam logic [3:0] OpBne = 4'd10;
  localparam logic [3:0] OpEca = 4'd15;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7_5 = 1'b0;
  logic       alu_bcond = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, mdr_write, old_pc_write;
  logic       pc_write, pc_source, aluout_write, reg_write, is_ecall, halt;
  logic [1:0] alu_src_a, alu_src_b, rd_src;
  logic [3:0] alu_op;
  logic [21:0] outs;

  int n_run  = 0;
  int n_fail = 0;
  logic [31:0] got, exp;

  assign outs = {mem_read, mem_write, iord, ir_write, mdr_write, old_pc_write, pc_write,
                 pc_source, aluout_write, alu_src_a, alu_src_b, alu_op, reg_write, rd_src,
                 is_ecall, halt};

  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(
    .AluOpW   (4),
    .EcallHalt(1'b1)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .opcode_i      (opcode),
    .funct3_i      (funct3),
    .funct7_5_i    (funct7_5),
    .alu_bcond_i   (alu_bcond),
    .mem_ready_i   (mem_ready),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .iord_o        (iord),
    .ir_write_o    (ir_write),
    .mdr_write_o   (mdr_write),
    .old_pc_write_o(old_pc_write),
    .pc_write_o    (pc_write),
    .pc_source_o   (pc_source),
    .aluout_write_o(aluout_write),
    .alu_src_a_o   (alu_src_a),
    .alu_src_b_o   (alu_src_b),
    .alu_op_o      (alu_op),
    .reg_write_o   (reg_write),
    .rd_src_o      (rd_src),
    .is_ecall_o    (is_ecall),
    .halt_o        (halt)
  );

  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode   = op;
    funct3   = f3;
    funct7_5 = f7;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; mem_ready = 1'b1;
    #3;
    got = 32'(outs); exp = 32'd0;
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL reset_outs: got %h want %h", got, exp); end
    cyc();
    rst_ni = 1'b1; mem_ready = 1'b0;
    #1;
    got = 32'({mem_read, iord, ir_write, pc_write, halt}); exp = 32'(5'b10000);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL reset_release_if: got %h want %h", got, exp); end
    cyc();
    got = 32'({mem_read, iord, ir_write, pc_write}); exp = 32'(4'b1000);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL if_wait: got %h want %h", got, exp); end
  endtask

  task automatic test_alu_add();
    set_ir(7'b0110011, 3'd0, 1'b0); mem_ready = 1'b1; alu_bcond = 1'b0;
    #1;
    got = 32'({mem_read, iord, ir_write, old_pc_write, pc_write, pc_source, alu_src_a, alu_src_b, alu_op});
    exp = 32'({1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, OpAdd});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL add_if: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({aluout_write, alu_src_a, alu_src_b, alu_op, mem_read, reg_write, ir_write});
    exp = 32'({1'b1, 2'd1, 2'd2, OpAdd, 1'b0, 1'b0, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL add_id: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({alu_src_a, alu_src_b, alu_op, aluout_write, reg_write, pc_write});
    exp = 32'({2'd2, 2'd0, OpAdd, 1'b1, 1'b0, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL add_ex: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({reg_write, rd_src, mem_read, mem_write}); exp = 32'({1'b1, 2'd0, 1'b0, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL add_wb: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, reg_write, ir_write}); exp = 32'(3'b101);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL add_back_if: got %h want %h", got, exp); end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ops [5] = '{7'h33, 7'h13, 7'h33, 7'h13, 7'h33};
    logic [2:0] f3s [5] = '{3'd0, 3'd0, 3'd5, 3'd7, 3'd2};
    logic       f7s [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] eop [5] = '{OpSub, OpAdd, OpSrl, OpAnd, OpSlt};
    logic [1:0] eb  [5] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
    for (int i = 0; i < 5; i++) begin
      set_ir(ops[i], f3s[i], f7s[i]); mem_ready = 1'b1;
      cyc(); cyc(); #1;
      got = 32'({alu_op, alu_src_a, alu_src_b}); exp = 32'({eop[i], 2'd2, eb[i]});
      n_run++; if (got !== exp) begin n_fail++; $display("FAIL alu_op_%0d: got %h want %h", i, got, exp); end
      cyc(); cyc();
    end
  endtask

  task automatic test_load();
    set_ir(7'b0000011, 3'd2, 1'b0); mem_ready = 1'b1;
    cyc(); cyc(); #1;
    got = 32'({alu_src_a, alu_src_b, alu_op, aluout_write, mem_read});
    exp = 32'({2'd2, 2'd2, OpAdd, 1'b1, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL lw_ex: got %h want %h", got, exp); end
    mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #1;
      got = 32'({mem_read, mem_write, iord, mdr_write, reg_write}); exp = 32'(5'b10100);
      n_run++; if (got !== exp) begin n_fail++; $display("FAIL lw_mem_wait_%0d: got %h want %h", i, got, exp); end
      cyc();
    end
    mem_ready = 1'b1; #1;
    got = 32'({mem_read, mem_write, iord, mdr_write}); exp = 32'(4'b1011);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL lw_mem_ready: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({reg_write, rd_src, mem_read}); exp = 32'({1'b1, 2'd1, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL lw_wb: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, iord}); exp = 32'(2'b10);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL lw_back_if: got %h want %h", got, exp); end
  endtask

  task automatic test_store();
    set_ir(7'b0100011, 3'd2, 1'b0); mem_ready = 1'b1;
    cyc(); cyc(); cyc(); #1;
    got = 32'({mem_read, mem_write, iord, mdr_write, reg_write}); exp = 32'(5'b01100);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL sw_mem: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, iord, mem_write, reg_write}); exp = 32'(4'b1000);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL sw_back_if: got %h want %h", got, exp); end
  endtask

  task automatic test_branch();
    for (int b = 1; b >= 0; b--) begin
      set_ir(7'b1100011, 3'd0, 1'b0); mem_ready = 1'b1; alu_bcond = 1'b0;
      cyc(); cyc();
      alu_bcond = b[0]; #1;
      got = 32'({pc_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write});
      exp = 32'({b[0], b[0], OpBeq, 2'd2, 2'd0, 1'b0});
      n_run++; if (got !== exp) begin n_fail++; $display("FAIL beq_ex_bcond%0d: got %h want %h", b, got, exp); end
      cyc(); alu_bcond = 1'b0; #1;
      got = 32'({mem_read, ir_write}); exp = 32'(2'b11);
      n_run++; if (got !== exp) begin n_fail++; $display("FAIL beq_back_if%0d: got %h want %h", b, got, exp); end
    end
    set_ir(7'b1100011, 3'd1, 1'b0);
    cyc(); cyc(); #1;
    got = 32'(alu_op); exp = 32'(OpBne);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL bne_ex_op: got %h want %h", got, exp); end
    cyc();
  endtask

  task automatic test_jump();
    set_ir(7'b1101111, 3'd0, 1'b0); mem_ready = 1'b1;
    cyc(); cyc(); #1;
    got = 32'({reg_write, rd_src, pc_write, pc_source}); exp = 32'({1'b1, 2'd2, 1'b1, 1'b1});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL jal_ex: got %h want %h", got, exp); end
    cyc();
    set_ir(7'b1100111, 3'd0, 1'b0);
    cyc(); cyc(); #1;
    got = 32'({reg_write, rd_src, pc_write, pc_source, alu_src_a, alu_src_b, alu_op});
    exp = 32'({1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 2'd2, OpAdd});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL jalr_ex: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, reg_write}); exp = 32'(2'b10);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL jalr_back_if: got %h want %h", got, exp); end
  endtask

  task automatic test_illegal();
    set_ir(7'h7F, 3'd0, 1'b0); mem_ready = 1'b1;
    cyc(); #1;
    got = 32'({reg_write, mem_write, mem_read, ir_write, aluout_write}); exp = 32'(5'b00001);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL illegal_id: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, ir_write, reg_write, mem_write}); exp = 32'(4'b1100);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL illegal_back_if: got %h want %h", got, exp); end
  endtask

  task automatic test_ecall();
    set_ir(7'b1110011, 3'd0, 1'b0); mem_ready = 1'b1; alu_bcond = 1'b0;
    cyc(); #1;
    got = 32'({is_ecall, halt}); exp = 32'(2'b10);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL ecall_id: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({is_ecall, alu_op, alu_src_a, halt}); exp = 32'({1'b1, OpEca, 2'd2, 1'b0});
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL ecall_ex: got %h want %h", got, exp); end
    cyc(); #1;
    got = 32'({mem_read, halt}); exp = 32'(2'b10);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL ecall_nohalt_if: got %h want %h", got, exp); end
    cyc(); cyc();
    alu_bcond = 1'b1;
    cyc();
    alu_bcond = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0]; #1;
      got = 32'({halt, mem_read, mem_write, pc_write, reg_write, ir_write}); exp = 32'(6'b100000);
      n_run++; if (got !== exp) begin n_fail++; $display("FAIL halt_hold_%0d: got %h want %h", i, got, exp); end
      cyc();
    end
  endtask

  task automatic test_reset_mid_store();
    rst_ni = 1'b0; #1;
    got = 32'(outs); exp = 32'd0;
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL halt_reset_outs: got %h want %h", got, exp); end
    cyc();
    rst_ni = 1'b1;
    set_ir(7'b0100011, 3'd2, 1'b0); mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0; #1;
    got = 32'({mem_write, iord}); exp = 32'(2'b11);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL sw_mid_mem: got %h want %h", got, exp); end
    #1 rst_ni = 1'b0;
    #1;
    got = 32'(outs); exp = 32'd0;
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL reset_mid_outs: got %h want %h", got, exp); end
    cyc();
    rst_ni = 1'b1; #1;
    got = 32'({mem_read, mem_write, iord, halt}); exp = 32'(4'b1000);
    n_run++; if (got !== exp) begin n_fail++; $display("FAIL post_reset_if: got %h want %h", got, exp); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_add();
    test_alu_ops();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_illegal();
    test_ecall();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
